vprobe_avg: RTL and testbench

Digital capture end of the voltage-probe path: takes signed samples from the probe digitiser, accumulates a fixed power-of-two number of them, and returns the arithmetic mean to the host over a valid/ready handshake. It is the reader counterpart of the DC source / port-excitation side of the LPF-balun test fixtures. It sits between the probe ADC interface and the measurement-collection logic.

---
 rtl/vprobe_avg_pkg.sv | 16 +
 rtl/vprobe_acc.sv | 45 ++++
 rtl/vprobe_avg.sv | 102 ++++++++++
 tb/tb_vprobe_avg.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vprobe_avg_pkg.sv
// Shared definitions for the voltage-probe capture path: FSM states and the
// accumulator width rule, also used by the port-excitation generator.
package vprobe_avg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // N samples of DATA_W bits sum into DATA_W + log2(N) bits without overflow.
  function automatic int acc_w(input int data_w, input int log2_n);
    return data_w + log2_n;
  endfunction

endpackage

// File: rtl/vprobe_acc.sv
// Signed sample accumulator with synchronous clear and add-enable. It also
// provides the floored mean of the sum that includes the sample being added.
module vprobe_acc
  import vprobe_avg_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              add_en,
  input  logic [DATA_W-1:0] smp_data,
  output logic [DATA_W-1:0] mean_nxt
);

  localparam int ACC_W = acc_w(DATA_W, LOG2_N);

  logic signed [DATA_W-1:0] smp_s;
  logic signed [ACC_W-1:0]  sum_nxt;
  logic signed [ACC_W-1:0]  acc_p0;

  // Arithmetic shift floors toward minus infinity, which is the intended mean.
  function automatic logic signed [DATA_W-1:0] floor_mean(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] shifted;
    shifted = sum >>> LOG2_N;
    return shifted[DATA_W-1:0];
  endfunction

  assign smp_s    = signed'(smp_data);
  assign sum_nxt  = acc_p0 + ACC_W'(smp_s);
  assign mean_nxt = floor_mean(sum_nxt);

  // p0: running sum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p0 <= '0;
    end else if (clr) begin
      acc_p0 <= '0;
    end else if (add_en) begin
      acc_p0 <= sum_nxt;
    end
  end

endmodule

// File: rtl/vprobe_avg.sv
// Probe capture top: averages 2^LOG2_N signed samples per start request and
// hands the mean to the host over a valid/ready handshake.
module vprobe_avg
  import vprobe_avg_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int LOG2_N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              smp_valid,
  input  logic [DATA_W-1:0] smp_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              overrun
);

  // One extra bit keeps the counter well-formed when LOG2_N is 0.
  localparam int               CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_N) - 1);

  state_t            state_p0;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt_p0;
  logic              acc_clr;
  logic              acc_add;
  logic              last_smp;
  logic [DATA_W-1:0] mean_nxt;

  assign acc_clr  = (state_p0 == IDLE) && start;
  assign acc_add  = (state_p0 == ACC) && smp_valid;
  assign last_smp = acc_add && (cnt_p0 == LAST_CNT);

  vprobe_acc #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (acc_clr),
    .add_en   (acc_add),
    .smp_data (smp_data),
    .mean_nxt (mean_nxt)
  );

  // p0: control state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
    end else begin
      state_p0 <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_p0;
    case (state_p0)
      IDLE:    if (start)     state_nxt = ACC;
      ACC:     if (last_smp)  state_nxt = HOLD;
      HOLD:    if (res_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_p0 != IDLE);
    res_valid = (state_p0 == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p0 <= '0;
    end else if (acc_clr) begin
      cnt_p0 <= '0;
    end else if (acc_add) begin
      cnt_p0 <= cnt_p0 + CNT_W'(1);
    end
  end

  // p1: result register, loaded with the mean that includes the final sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (last_smp) begin
      res_data <= mean_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (acc_clr) begin
      overrun <= 1'b0;
    end else if ((state_p0 == HOLD) && smp_valid) begin
      overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vprobe_avg.sv
// Scoreboarded bench for vprobe_avg: stimulus queues the expected floored mean,
// a negedge monitor compares it at every completed result handshake.
module tb_vprobe_avg;

  localparam int DATA_W = 12;
  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              smp_valid = 1'b0;
  logic [DATA_W-1:0] smp_data = '0;
  logic              res_ready = 1'b0;
  logic              res_valid;
  logic [DATA_W-1:0] res_data;
  logic              busy;
  logic              overrun;

  int n_chk  = 0;
  int n_pass = 0;
  int exp_q[$];
  int vals[N];

  vprobe_avg #(
    .DATA_W (DATA_W),
    .LOG2_N (LOG2_N)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference: integer mean of the samples, floored toward minus infinity.
  function automatic int model_mean();
    int sum;
    sum = 0;
    foreach (vals[i]) sum += vals[i];
    if (sum >= 0) return sum / N;
    return -((-sum + N - 1) / N);
  endfunction

  function automatic int rnd_smp();
    return int'($urandom_range(0, (1 << DATA_W) - 1)) - (1 << (DATA_W - 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v);
    smp_valid = 1'b1;
    smp_data  = DATA_W'(v);
    tick();
    smp_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  // Feed vals[]; gap < 0 means random gaps; restart_at inserts a stray start.
  task automatic feed(input int gap, input int restart_at);
    int g;
    exp_q.push_back(model_mean());
    for (int i = 0; i < N; i++) begin
      if (i == restart_at) begin
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("no_restart_busy", int'(busy), 1);
      end
      chk("no_early_result", int'(res_valid), 0);
      send(vals[i]);
      if (i != N - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) tick();
      end
    end
    chk("result_latency", int'(res_valid), 1);
  endtask

  task automatic handshake(input int delay);
    repeat (delay) begin
      tick();
      chk("hold_valid", int'(res_valid), 1);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("busy_after_hs", int'(busy), 0);
    chk("valid_after_hs", int'(res_valid), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("unexpected_result", 1, 0);
      else chk("res_data", int'($signed(res_data)), exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_exp;
    repeat (3) tick();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_data", int'(res_data), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick();

    // Constant +100
    foreach (vals[i]) vals[i] = 100;
    do_start();
    feed(0, -1);
    chk("overrun_clean", int'(overrun), 0);
    handshake(0);

    // Alternating extremes, then all -1: both floor to -1
    foreach (vals[i]) vals[i] = (i % 2 == 0) ? -2048 : 2047;
    do_start();
    feed(0, -1);
    handshake(0);
    foreach (vals[i]) vals[i] = -1;
    do_start();
    feed(0, -1);
    handshake(1);

    // Samples before start are ignored; gapped samples 1 cycle in 3
    repeat (3) send(2000);
    chk("idle_ignores_smp", int'(busy), 0);
    foreach (vals[i]) vals[i] = rnd_smp();
    do_start();
    feed(2, -1);
    handshake(0);

    // Held result with overrun pulses
    foreach (vals[i]) vals[i] = rnd_smp();
    hold_exp = model_mean();
    do_start();
    feed(0, -1);
    for (int c = 0; c < 10; c++) begin
      smp_valid = (c == 2 || c == 5 || c == 8);
      smp_data  = DATA_W'(rnd_smp());
      tick();
      smp_valid = 1'b0;
      chk("hold_data_stable", int'($signed(res_data)), hold_exp);
      chk("hold_valid_stable", int'(res_valid), 1);
    end
    chk("overrun_set", int'(overrun), 1);
    handshake(0);
    chk("overrun_sticky", int'(overrun), 1);
    do_start();
    chk("overrun_cleared", int'(overrun), 0);
    foreach (vals[i]) vals[i] = rnd_smp();
    feed(0, 5);
    handshake(0);

    // Async reset mid-measurement discards everything
    do_start();
    repeat (8) send(1500);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_valid", int'(res_valid), 0);
    tick();
    rst_n = 1'b1;
    tick();
    foreach (vals[i]) vals[i] = 7;
    do_start();
    feed(0, -1);
    handshake(0);

    // start together with ready in HOLD: handshake only, no new measurement
    foreach (vals[i]) vals[i] = rnd_smp();
    do_start();
    feed(0, -1);
    start     = 1'b1;
    res_ready = 1'b1;
    tick();
    start     = 1'b0;
    res_ready = 1'b0;
    chk("start_ready_idle", int'(busy), 0);
    tick();
    chk("start_ready_stay_idle", int'(busy), 0);

    // Random measurements
    for (int m = 0; m < 6; m++) begin
      foreach (vals[i]) vals[i] = rnd_smp();
      do_start();
      feed(-1, -1);
      handshake(int'($urandom_range(0, 3)));
      repeat (int'($urandom_range(0, 2))) tick();
    end

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
